audio_sample_sequencer: RTL and testbench

- Paces a stream of signed 16-bit PCM samples into the second-order sigma-delta DAC at a programmable sample rate.
- Buffers host-supplied samples in a small FIFO. Host samples arrive from the JTAG-side loader over a valid/ready handshake.
- Applies a shift-based volume attenuation before each sample reaches the DAC input.
- Detects and flags underruns. Sits between the loader and the DAC's 16-bit data input.

---
 rtl/audio_sample_sequencer.sv | 164 ++++++++++++++++
 tb/tb_audio_sample_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_sequencer.sv
// Purpose: paces buffered signed PCM samples into the sigma-delta DAC at a programmable rate, with shift volume and underrun detection.
// Latency: first pop i_divisor+1 cycles after entering PLAY; tick to o_sample/o_sample_strobe is 1 cycle.
// Backpressure: o_s_ready drops only when the 16-entry FIFO is full; pushes are accepted and discarded while idle or disabling.

module sample_fifo #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_res,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic [AW:0]   level
);
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            case ({push_vld, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge i_clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module audio_sample_sequencer #(
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_res,
    input  logic               i_enable,
    input  logic [DIV_W-1:0]   i_divisor,
    input  logic [3:0]         i_volume,
    input  logic [15:0]        i_s_data,
    input  logic               i_s_valid,
    output logic               o_s_ready,
    output logic [15:0]        o_sample,
    output logic               o_sample_strobe,
    output logic               o_underrun,
    input  logic               i_clear_underrun,
    output logic [FIFO_AW:0]   o_level,
    output logic               o_playing
);
    localparam logic [FIFO_AW:0] LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] LVL_HALF = {2'b01, {(FIFO_AW-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_PLAY} state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic              flush;
    logic              pop;
    logic              push_vld;
    logic              underrun_set;
    logic [15:0]       head_dat;
    logic signed [15:0] shaped;

    assign o_s_ready = (o_level != LVL_FULL);
    assign push_vld  = i_s_valid & o_s_ready;
    assign o_playing = (state == ST_PLAY);
    assign shaped    = $signed(head_dat) >>> i_volume;

    sample_fifo #(.DW(16), .AW(FIFO_AW)) u_fifo (
        .i_clk    (i_clk),
        .i_res    (i_res),
        .flush    (flush),
        .push_vld (push_vld),
        .push_dat (i_s_data),
        .pop      (pop),
        .head_dat (head_dat),
        .level    (o_level)
    );

    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        div_nxt      = div_cnt;
        flush        = 1'b0;
        pop          = 1'b0;
        underrun_set = 1'b0;
        case (state)
            ST_IDLE: begin
                flush   = 1'b1;
                div_nxt = '0;
                if (i_enable) state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                if (!i_enable) begin
                    flush     = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (o_level >= LVL_HALF) begin
                    div_nxt   = i_divisor;
                    state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Disabling wins over a coincident tick, so nothing is popped on the way out.
                if (!i_enable) begin
                    flush     = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (div_cnt == '0) begin
                    div_nxt = i_divisor;
                    if (o_level != '0) begin
                        pop = 1'b1;
                    end else begin
                        underrun_set = 1'b1;
                        state_nxt    = ST_PRIME;
                    end
                end else begin
                    div_nxt = div_cnt - DIV_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            o_sample        <= 16'h0000;
            o_sample_strobe <= 1'b0;
            o_underrun      <= 1'b0;
        end else begin
            o_sample_strobe <= pop;
            if (flush)    o_sample <= 16'h0000;
            else if (pop) o_sample <= shaped;
            if (underrun_set)          o_underrun <= 1'b1;
            else if (i_clear_underrun) o_underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Directed bench for audio_sample_sequencer: reset, priming/rate, backpressure, volume, underrun, disable and async reset.
module tb_audio_sample_sequencer;
    logic        i_clk;
    logic        i_res;
    logic        i_enable;
    logic [15:0] i_divisor;
    logic [3:0]  i_volume;
    logic [15:0] i_s_data;
    logic        i_s_valid;
    logic        o_s_ready;
    logic [15:0] o_sample;
    logic        o_sample_strobe;
    logic        o_underrun;
    logic        i_clear_underrun;
    logic [4:0]  o_level;
    logic        o_playing;

    int n_vec = 0;
    int n_err = 0;

    audio_sample_sequencer #(.FIFO_AW(4), .DIV_W(16)) dut (
        .i_clk            (i_clk),
        .i_res            (i_res),
        .i_enable         (i_enable),
        .i_divisor        (i_divisor),
        .i_volume         (i_volume),
        .i_s_data         (i_s_data),
        .i_s_valid        (i_s_valid),
        .o_s_ready        (o_s_ready),
        .o_sample         (o_sample),
        .o_sample_strobe  (o_sample_strobe),
        .o_underrun       (o_underrun),
        .i_clear_underrun (i_clear_underrun),
        .o_level          (o_level),
        .o_playing        (o_playing)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic push(input logic [15:0] d);
        i_s_valid = 1'b1;
        i_s_data  = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_playing(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge i_clk);
            if (o_playing) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_strobe(input int max, output int cycles, output logic [15:0] val);
        cycles = -1;
        val    = 16'hxxxx;
        for (int n = 1; n <= max; n++) begin
            @(negedge i_clk);
            if (o_sample_strobe) begin
                cycles = n;
                val    = o_sample;
                break;
            end
        end
    endtask

    task automatic go_idle();
        i_enable         = 1'b0;
        i_s_valid        = 1'b0;
        i_clear_underrun = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_clear_underrun = 1'b0;
    endtask

    task automatic start_prime(input logic [15:0] div, input logic [3:0] vol);
        i_divisor = div;
        i_volume  = vol;
        i_enable  = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        n_vec++; if (o_level !== 5'd0) begin n_err++; $display("FAIL rst_level got=%0d exp=0", o_level); end
        n_vec++; if (o_sample !== 16'h0000) begin n_err++; $display("FAIL rst_sample got=%h exp=0000", o_sample); end
        n_vec++; if ({o_underrun, o_playing, o_sample_strobe} !== 3'b000) begin n_err++; $display("FAIL rst_flags got=%b exp=000", {o_underrun, o_playing, o_sample_strobe}); end
        @(posedge i_clk); #1; i_res = 1'b1;
        push(16'h1111); push(16'h2222); push(16'h3333);
        i_s_valid = 1'b0;
        @(negedge i_clk);
        n_vec++; if (o_level !== 5'd0) begin n_err++; $display("FAIL idle_level got=%0d exp=0", o_level); end
        n_vec++; if (o_s_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready got=%b exp=1", o_s_ready); end
        n_vec++; if ({o_playing, o_sample} !== 17'h0) begin n_err++; $display("FAIL idle_out got=%h exp=0", {o_playing, o_sample}); end
    endtask

    task automatic test_priming_rate();
        bit ok; int c; logic [15:0] v;
        start_prime(16'd3, 4'd0);
        push(16'h1000); push(16'hF000);
        for (int k = 1; k <= 6; k++) push(16'(k));
        i_s_valid = 1'b0;
        wait_playing(ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL prime_play got=%b exp=1", ok); end
        wait_strobe(20, c, v);
        n_vec++; if (c !== 4 || v !== 16'h1000) begin n_err++; $display("FAIL first_strobe got=%0d/%h exp=4/1000", c, v); end
        wait_strobe(20, c, v);
        n_vec++; if (c !== 4 || v !== 16'hF000) begin n_err++; $display("FAIL second_strobe got=%0d/%h exp=4/f000", c, v); end
        go_idle();
    endtask

    task automatic test_full();
        int c; logic [15:0] v;
        start_prime(16'd40, 4'd0);
        for (int k = 0; k < 16; k++) push(16'h0A00 + 16'(k));
        i_s_valid = 1'b0;
        @(negedge i_clk);
        n_vec++; if (o_level !== 5'd16 || o_s_ready !== 1'b0) begin n_err++; $display("FAIL full_state got=%0d/%b exp=16/0", o_level, o_s_ready); end
        push(16'hDEAD);
        @(negedge i_clk);
        n_vec++; if (o_level !== 5'd16) begin n_err++; $display("FAIL full_reject got=%0d exp=16", o_level); end
        i_s_data = 16'hBEEF;
        wait_strobe(80, c, v);
        n_vec++; if (c < 0 || v !== 16'h0A00 || o_level !== 5'd15 || o_s_ready !== 1'b1) begin n_err++; $display("FAIL full_pop got=%h/%0d/%b exp=0a00/15/1", v, o_level, o_s_ready); end
        @(negedge i_clk);
        n_vec++; if (o_level !== 5'd16) begin n_err++; $display("FAIL full_refill got=%0d exp=16", o_level); end
        go_idle();
    endtask

    task automatic test_push_pop();
        int played = 0;
        start_prime(16'd0, 4'd0);
        i_s_valid = 1'b1;
        i_s_data  = 16'h0100;
        for (int i = 0; i < 30; i++) begin
            @(posedge i_clk); #1;
            i_s_data = i_s_data + 16'd1;
            @(negedge i_clk);
            if (o_playing) played++;
            if (played >= 2 && played <= 8) begin
                n_vec++;
                if (o_sample_strobe !== 1'b1 || o_sample !== 16'h0100 + 16'(played - 2) || o_level !== 5'd9) begin
                    n_err++;
                    $display("FAIL pushpop_%0d got=%b/%h/%0d exp=1/%h/9", played, o_sample_strobe, o_sample, o_level, 16'h0100 + 16'(played - 2));
                end
            end
        end
        n_vec++; if (played < 8) begin n_err++; $display("FAIL pushpop_play got=%0d exp>=8", played); end
        go_idle();
    endtask

    task automatic test_volume(input logic [3:0] vol, input logic [15:0] e0, input logic [15:0] e1);
        bit ok; int c; logic [15:0] v;
        start_prime(16'd3, vol);
        push(16'h8000); push(16'h7FFF);
        for (int k = 0; k < 6; k++) push(16'h0000);
        i_s_valid = 1'b0;
        wait_playing(ok);
        wait_strobe(20, c, v);
        n_vec++; if (v !== e0) begin n_err++; $display("FAIL vol%0d_neg got=%h exp=%h", vol, v, e0); end
        wait_strobe(20, c, v);
        n_vec++; if (v !== e1) begin n_err++; $display("FAIL vol%0d_pos got=%h exp=%h", vol, v, e1); end
        go_idle();
    endtask

    task automatic test_underrun();
        bit ok;
        start_prime(16'd0, 4'd0);
        for (int k = 1; k <= 8; k++) push(16'(k));
        i_s_valid = 1'b0;
        wait_playing(ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL ur_play got=%b exp=1", ok); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk);
            n_vec++;
            if (o_sample_strobe !== 1'b1 || o_sample !== 16'(k)) begin n_err++; $display("FAIL ur_strobe%0d got=%b/%h exp=1/%h", k, o_sample_strobe, o_sample, 16'(k)); end
        end
        i_clear_underrun = 1'b1;
        @(negedge i_clk);
        n_vec++;
        if ({o_underrun, o_sample_strobe, o_playing} !== 3'b100 || o_sample !== 16'h0008) begin
            n_err++;
            $display("FAIL ur_set got=%b/%h exp=100/0008", {o_underrun, o_sample_strobe, o_playing}, o_sample);
        end
        @(negedge i_clk);
        i_clear_underrun = 1'b0;
        n_vec++; if (o_underrun !== 1'b0) begin n_err++; $display("FAIL ur_clear got=%b exp=0", o_underrun); end
        go_idle();
    endtask

    task automatic test_disable();
        bit ok; int c; logic [15:0] v;
        start_prime(16'd3, 4'd0);
        for (int k = 0; k < 8; k++) push(16'h5000 + 16'(k));
        i_s_valid = 1'b0;
        wait_playing(ok);
        repeat (3) wait_strobe(20, c, v);
        n_vec++; if (o_level !== 5'd5 || v !== 16'h5002) begin n_err++; $display("FAIL dis_pre got=%0d/%h exp=5/5002", o_level, v); end
        i_enable = 1'b0;
        @(negedge i_clk);
        n_vec++;
        if (o_playing !== 1'b0 || o_level !== 5'd0 || o_sample !== 16'h0000 || o_sample_strobe !== 1'b0) begin
            n_err++;
            $display("FAIL dis_post got=%b/%0d/%h/%b exp=0/0/0000/0", o_playing, o_level, o_sample, o_sample_strobe);
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        bit ok; int c; logic [15:0] v;
        start_prime(16'd3, 4'd0);
        for (int k = 0; k < 8; k++) push(16'h1234);
        i_s_valid = 1'b0;
        wait_playing(ok);
        wait_strobe(20, c, v);
        n_vec++; if (v !== 16'h1234) begin n_err++; $display("FAIL ar_pre got=%h exp=1234", v); end
        #2 i_res = 1'b0;
        #1;
        n_vec++;
        if (o_level !== 5'd0 || o_sample !== 16'h0000 || o_playing !== 1'b0 || o_sample_strobe !== 1'b0 || o_s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ar_post got=%0d/%h/%b/%b/%b exp=0/0000/0/0/1", o_level, o_sample, o_playing, o_sample_strobe, o_s_ready);
        end
        i_enable = 1'b0;
        @(posedge i_clk); #1;
        i_res = 1'b1;
        go_idle();
    endtask

    initial begin
        i_res = 1'b0;
        i_enable = 1'b0;
        i_divisor = 16'd0;
        i_volume = 4'd0;
        i_s_data = 16'h0000;
        i_s_valid = 1'b0;
        i_clear_underrun = 1'b0;
        test_reset();
        test_priming_rate();
        test_full();
        test_push_pop();
        test_volume(4'd4, 16'hF800, 16'h07FF);
        test_volume(4'd15, 16'hFFFF, 16'h0000);
        test_underrun();
        test_disable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
